fifo_uart_drain: RTL
====================

# fifo_uart_drain

Drains bytes from the read side of the camera FIFO and transmits them through the UART transmitter, one byte per UART frame. It is the return path of the UART-to-FIFO capture path. Bytes are grouped into packets of at most `PKT_LEN` bytes. A packet ends early when the FIFO runs empty or `enable` drops.

## Interface
Parameters:
- `PKT_LEN`, default 16: maximum number of data bytes per packet. Legal range is 1..255.
- `HDR_BYTE`, default 8'hA0: header byte sent at the start of each packet when the header feature is enabled.

Ports:
- `clk`  in  1  system clock. One clock domain only; FIFO read side and UART both run on `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  allows a new packet to start. Deasserting it ends the packet after the byte currently in flight.
- `empy`  in  1  FIFO empty flag.
- `rd`  out  1  FIFO read strobe. Each cycle it is high pops exactly one byte.
- `datout`  in  8  FIFO read data. Valid on the cycle after `rd`.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_wr`  out  1  one-cycle write strobe to the UART.
- `tx_data`  out  8  byte presented to the UART. Stable while `tx_wr` is high.
- `pkt_done`  out  1  one-cycle pulse when a packet ends.
- `byte_cnt`  out  16  running count of data bytes sent. Header bytes are not counted.

## Operation
- **Reset values:** `rd`=0, `tx_wr`=0, `tx_data`=8'h00, `pkt_done`=0, `byte_cnt`=0. State is IDLE and the packet counter `pcnt` is 0.
- **UART contract:** the UART accepts `tx_wr` only when `tx_busy`=0, and raises `tx_busy` in the next cycle. `tx_wr` is never asserted while `tx_busy`=1.
- **IDLE:**
  - Stays in IDLE while `enable`=0 or `empy`=1.
  - Otherwise clears `pcnt` and goes to HDR if the header feature is compiled in, else to RD.
- **HDR:** when `tx_busy`=0, drives `tx_data`=`HDR_BYTE` with `tx_wr`=1, then goes to WAIT with return target RD.
- **RD:**
  - If `empy`=0: `rd`=1, then go to LAT.
  - If `empy`=1: pulse `pkt_done`, then go to IDLE. This covers the case where the header was sent but the FIFO has since emptied.
- **LAT:** registers `datout` into `tx_data`, then goes to SEND.
- **SEND:**
  - When `tx_busy`=0: `tx_wr`=1, `pcnt`+1, `byte_cnt`+1, then go to WAIT.
  - Holds in SEND while `tx_busy`=1.
- **WAIT:**
  - The first cycle is a guard cycle; `tx_busy` is ignored.
  - After the guard cycle, waits for `tx_busy`=0.
  - Then, if `pcnt`==`PKT_LEN`, or `empy`=1, or `enable`=0: pulse `pkt_done` and go to IDLE.
  - Otherwise go to RD.
- **Counter width:** `pcnt` is 8 bits. `byte_cnt` wraps from 16'hFFFF to 0 silently.
- **No byte loss:** every byte popped from the FIFO is transmitted, except when `reset` is asserted between RD and SEND. A reset mid-operation discards that byte and any frame in progress; the UART is reset by the same `reset`.
- **`enable` drop:** the current byte always completes. The packet then ends at WAIT.

## Timing
- **Data path, header feature out:**
  - Cycle 0: IDLE sees `enable`=1 and `empy`=0.
  - Cycle 1: `rd`=1.
  - Cycle 2: `datout` is captured.
  - Cycle 3: `tx_wr`=1, provided `tx_busy`=0.
- **Header path, header feature in:** header `tx_wr` in cycle 1; the first data `tx_wr` follows the header's WAIT.
- **Byte spacing:** back-to-back bytes need `tx_busy` low, then RD, LAT, SEND, i.e. 3 cycles after `tx_busy` falls.
- **`pkt_done`:** asserted in the cycle the FSM leaves WAIT or RD for IDLE. IDLE may start a new packet on the following cycle.
- **`empy`:** sampled only in IDLE, RD and WAIT. A write arriving while the FSM is in another state is seen at the next sampling point.

## Configuration
- Macro `FIFO_UART_HDR_EN`.
- **Defined:** the HDR state exists, and each packet is preceded by `HDR_BYTE`.
- **Undefined:** the HDR state is removed, IDLE goes straight to RD, and only raw data bytes are sent.
- `byte_cnt` and `pkt_done` behave the same in both builds.

## Structure
- **Shared package `camera_fifo_pkg`:**
  - State enum: IDLE, HDR, RD, LAT, SEND, WAIT.
  - Constant `DEF_HDR_BYTE` = 8'hA0.
  - Constant `DEF_PKT_LEN` = 16.
- **Sub-modules:** none. A single FSM module; the UART and FIFO are instantiated by the parent.

## Test plan
- **Single byte:** FIFO holds 8'h55, `enable`=1, header feature out → one `rd`; `tx_wr` with `tx_data`=8'h55 in cycle 3; `pkt_done` after `tx_busy` falls; `byte_cnt`=1.
- **Header:** header feature in, FIFO holds 8'h01, 8'h02 → UART sees A0, 01, 02 in order; one `pkt_done`; `byte_cnt`=2.
- **Packet split:** `PKT_LEN`=4, FIFO holds 10 bytes 0..9 → packets of 4, 4, 2 bytes; three `pkt_done` pulses; all bytes in order; `rd` never high with `empy`=1.
- **UART back-pressure:** hold `tx_busy`=1 for 50 cycles after the first `tx_wr` → no second `tx_wr` until it drops; no extra FIFO pops.
- **Enable drop mid-packet:** deassert `enable` during byte 2 of 8 → byte 2 still sent, `pkt_done` follows, 6 bytes remain in the FIFO; re-enable → the remaining 6 are sent.
- **Reset mid-operation:** assert `reset` in LAT → all outputs return to reset values the next cycle; `byte_cnt`=0; the FSM restarts from IDLE.

Source files
------------

// File: rtl/camera_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : camera_fifo_pkg
//  Description : Shared types and defaults for the camera FIFO return path.
//                Holds the drain FSM state encoding and the default packet
//                length / header byte used by fifo_uart_drain.
//  Revision    : 1.0 - initial release
// ============================================================================
package camera_fifo_pkg;

   // Drain FSM states. HDR is only reachable when the header build is used.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      RD   = 3'd2,
      LAT  = 3'd3,
      SEND = 3'd4,
      WAIT = 3'd5
   } state_t;

   localparam logic [7:0] DEF_HDR_BYTE = 8'hA0;
   localparam int         DEF_PKT_LEN  = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_drain
//  Description : Pops bytes from the camera FIFO read side and hands them to
//                the UART transmitter, one byte per frame, grouped into
//                packets of at most PKT_LEN bytes. A packet also ends when
//                the FIFO runs empty or enable drops.
//  Build option: define FIFO_UART_HDR_EN to prefix each packet with HDR_BYTE.
//  Ports       : clk      - system clock (FIFO and UART share it)
//                reset    - synchronous, active-high reset
//                enable   - allows a new packet to start
//                empy     - FIFO empty flag
//                rd       - FIFO pop strobe (one byte per high cycle)
//                datout   - FIFO read data, valid the cycle after rd
//                tx_busy  - UART busy
//                tx_wr    - one-cycle UART write strobe
//                tx_data  - byte presented to the UART
//                pkt_done - one-cycle pulse when a packet ends
//                byte_cnt - running count of data bytes sent (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_drain
   import camera_fifo_pkg::*;
#(
   parameter int         PKT_LEN  = DEF_PKT_LEN,
   parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        empy,
   output logic        rd,
   input  logic [7:0]  datout,
   input  logic        tx_busy,
   output logic        tx_wr,
   output logic [7:0]  tx_data,
   output logic        pkt_done,
   output logic [15:0] byte_cnt
);

   localparam logic [7:0] c_pkt_len = 8'(PKT_LEN);

   state_t      state_q,    state_d;
   logic [7:0]  pcnt_q,     pcnt_d;
   logic [7:0]  tx_data_q,  tx_data_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic        guard_q,    guard_d;    // first WAIT cycle, tx_busy not yet valid
   logic        ret_rd_q,   ret_rd_d;   // WAIT entered from HDR: always go on to RD

`ifndef FIFO_UART_HDR_EN
   // Header byte is not transmitted in this build.
   logic [7:0] unused_hdr;
   assign unused_hdr = HDR_BYTE;
`endif

   // rd, tx_wr and pkt_done are decoded from the current state and inputs so
   // that the strobe lands in the same cycle the FSM takes the action
   // (rd in cycle 1, tx_wr in cycle 3 of the data path).
   always_comb begin
      state_d    = state_q;
      pcnt_d     = pcnt_q;
      tx_data_d  = tx_data_q;
      byte_cnt_d = byte_cnt_q;
      guard_d    = guard_q;
      ret_rd_d   = ret_rd_q;
      rd         = 1'b0;
      tx_wr      = 1'b0;
      pkt_done   = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable && !empy) begin
               pcnt_d = 8'd0;
`ifdef FIFO_UART_HDR_EN
               // Preload the header so tx_data is already valid in HDR.
               tx_data_d = HDR_BYTE;
               state_d   = HDR;
`else
               state_d   = RD;
`endif
            end
         end
`ifdef FIFO_UART_HDR_EN
         HDR: begin
            if (!tx_busy) begin
               tx_wr    = 1'b1;
               guard_d  = 1'b1;
               ret_rd_d = 1'b1;
               state_d  = WAIT;
            end
         end
`endif
         RD: begin
            if (!empy) begin
               rd      = 1'b1;
               state_d = LAT;
            end else begin
               // Header went out but the FIFO emptied meanwhile.
               pkt_done = 1'b1;
               state_d  = IDLE;
            end
         end
         LAT: begin
            tx_data_d = datout;
            state_d   = SEND;
         end
         SEND: begin
            if (!tx_busy) begin
               tx_wr      = 1'b1;
               pcnt_d     = pcnt_q + 8'd1;
               byte_cnt_d = byte_cnt_q + 16'd1;
               guard_d    = 1'b1;
               ret_rd_d   = 1'b0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!tx_busy) begin
               if (ret_rd_q) begin
                  state_d = RD;
               end else if ((pcnt_q == c_pkt_len) || empy || !enable) begin
                  pkt_done = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pcnt_q     <= 8'd0;
         tx_data_q  <= 8'h00;
         byte_cnt_q <= 16'd0;
         guard_q    <= 1'b0;
         ret_rd_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         tx_data_q  <= tx_data_d;
         byte_cnt_q <= byte_cnt_d;
         guard_q    <= guard_d;
         ret_rd_q   <= ret_rd_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign byte_cnt = byte_cnt_q;

endmodule
`default_nettype wire
